fc_pe_seq: RTL and testbench

Sequencer and accumulator that drives one 1x3 floating-point PE (three multipliers, a three-input adder, a bias adder, four registered stages) for the fully-connected layer. It accepts a stream of data/kernel triples for one output neuron and generates the PE stage strobes with correct alignment. Bias is injected on the first triple only, and the PE partial results are accumulated into one dot-product result per vector. It sits between the FC weight/activation buffers and the PE, and owns the PE control strobes.

---
 rtl/fc_pe_seq_pkg.sv | 28 ++
 rtl/fc_pe_seq_fp_adder2.sv | 119 +++++++++++
 rtl/fc_pe_seq.sv | 133 +++++++++++++
 tb/tb_fc_pe_seq.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pe_seq_pkg.sv
// Shared definitions for the FC layer PE sequencer: word width, FSM states
// and the stage map of the four-deep PE pipeline.
package fc_pe_seq_pkg;

    localparam int PE_STAGES   = 4;
    localparam int STAGE_ALIGN = 0;
    localparam int STAGE_SUM   = 1;
    localparam int STAGE_BIAS  = 2;
    localparam int STAGE_RET   = PE_STAGES - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // One tag per PE stage; it travels alongside the triple inside the PE.
    typedef struct packed {
        logic v;
        logic first;
        logic last;
    } tag_t;

    function automatic int fp_width(input int exponent, input int mantissa);
        return 1 + exponent + mantissa;
    endfunction

endpackage

// File: rtl/fc_pe_seq_fp_adder2.sv
// Combinational two-input floating-point adder with round-to-nearest-even.
// Subnormal inputs are flushed to zero; inf/NaN operands propagate.
module fp_adder2 #(
    parameter int EXPONENT = 8,
    parameter int MANTISSA = 23
) (
    input  logic [EXPONENT+MANTISSA:0] i_a,
    input  logic [EXPONENT+MANTISSA:0] i_b,
    output logic [EXPONENT+MANTISSA:0] o_sum
);

    localparam int W  = 1 + EXPONENT + MANTISSA;
    localparam int MW = MANTISSA + 4;
    localparam logic [EXPONENT-1:0] EXP_MAX = '1;

    logic [W-1:0]        w_x;
    logic [W-1:0]        w_y;
    logic                w_sx;
    logic                w_sy;
    logic [EXPONENT-1:0] w_ex;
    logic [EXPONENT-1:0] w_ey;
    logic [EXPONENT-1:0] w_d;
    logic [MW-1:0]       w_mx;
    logic [MW-1:0]       w_my;
    logic [MW-1:0]       w_my_sh;
    logic [MW-1:0]       w_mask;
    logic                w_sticky;
    logic [MW:0]         w_raw;
    logic [MW-1:0]       w_norm;
    int                  w_lz;
    int                  w_exp_n;
    int                  w_exp_r;
    logic                w_round_up;
    logic [MANTISSA+1:0] w_mant_r;
    logic [MANTISSA-1:0] w_frac;

    function automatic int lzc(input logic [MW-1:0] v);
        int n;
        n = MW;
        for (int i = 0; i < MW; i++) begin
            if (v[i]) n = MW - 1 - i;
        end
        return n;
    endfunction

    // x is always the operand of larger magnitude, so the subtraction never goes negative.
    always_comb begin
        if (i_a[W-2:0] >= i_b[W-2:0]) begin
            w_x = i_a;
            w_y = i_b;
        end else begin
            w_x = i_b;
            w_y = i_a;
        end
        w_sx = w_x[W-1];
        w_sy = w_y[W-1];
        w_ex = w_x[W-2:MANTISSA];
        w_ey = w_y[W-2:MANTISSA];
        w_d  = w_ex - w_ey;
        w_mx = {1'b1, w_x[MANTISSA-1:0], 3'b000};
        w_my = (w_ey == '0) ? '0 : {1'b1, w_y[MANTISSA-1:0], 3'b000};
    end

    always_comb begin
        w_mask = ~({MW{1'b1}} << w_d);
        if (int'(w_d) >= MW) begin
            w_my_sh  = '0;
            w_sticky = |w_my;
        end else begin
            w_my_sh  = w_my >> w_d;
            w_sticky = |(w_my & w_mask);
        end
    end

    always_comb begin
        if (w_sx == w_sy) w_raw = {1'b0, w_mx} + {1'b0, w_my_sh | MW'(w_sticky)};
        else              w_raw = {1'b0, w_mx} - {1'b0, w_my_sh | MW'(w_sticky)};
    end

    always_comb begin
        w_lz = lzc(w_raw[MW-1:0]);
        if (w_raw[MW]) begin
            w_norm  = {w_raw[MW:2], w_raw[1] | w_raw[0]};
            w_exp_n = int'(w_ex) + 1;
        end else begin
            w_norm  = w_raw[MW-1:0] << w_lz;
            w_exp_n = int'(w_ex) - w_lz;
        end
    end

    // Guard/round/sticky sit in w_norm[2:0]; a carry out of rounding bumps the exponent.
    always_comb begin
        w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_mant_r   = {1'b0, w_norm[MW-1:3]} + (MANTISSA+2)'(w_round_up);
        w_exp_r    = w_mant_r[MANTISSA+1] ? w_exp_n + 1 : w_exp_n;
        w_frac     = w_mant_r[MANTISSA+1] ? w_mant_r[MANTISSA:1] : w_mant_r[MANTISSA-1:0];
    end

    always_comb begin
        o_sum = {w_sx, w_exp_r[EXPONENT-1:0], w_frac};
        if (w_ex == EXP_MAX) begin
            if (w_ey == EXP_MAX && w_sx != w_sy)
                o_sum = {1'b0, EXP_MAX, 1'b1, {(MANTISSA-1){1'b0}}};
            else
                o_sum = w_x;
        end else if (w_ex == '0) begin
            o_sum = {w_sx & w_sy, {(W-1){1'b0}}};
        end else if (w_ey == '0) begin
            o_sum = w_x;
        end else if (w_raw == '0) begin
            o_sum = '0;
        end else if (w_exp_r >= int'(EXP_MAX)) begin
            o_sum = {w_sx, EXP_MAX, {MANTISSA{1'b0}}};
        end else if (w_exp_r <= 0) begin
            o_sum = {w_sx, {(W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/fc_pe_seq.sv
// Sequencer/accumulator for one 1x3 FP PE: tags each accepted triple through the
// four PE stages, injects the bias on the first triple and sums PE outputs per vector.
module fc_pe_seq
    import fc_pe_seq_pkg::*;
#(
    parameter int EXPONENT = 8,
    parameter int MANTISSA = 23,
    localparam int W = fp_width(EXPONENT, MANTISSA)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   bias_i,
    input  logic [3*W-1:0] data3_i,
    input  logic [3*W-1:0] ker3_i,
    input  logic           in_valid,
    input  logic           in_last,
    output logic           in_ready,
    output logic [3*W-1:0] pe_data3_o,
    output logic [3*W-1:0] pe_ker3_o,
    output logic [W-1:0]   pe_bias_o,
    output logic           pe_on_3mul_pe_en,
    output logic           pe_on_align3,
    output logic           pe_on_sum3,
    output logic           pe_on_bias,
    input  logic [W-1:0]   pe_data_i,
    output logic [W-1:0]   result_o,
    output logic           result_valid,
    output logic           busy,
    output logic [1:0]     o_dbg_state
);

    state_t       r_state;
    state_t       w_next;
    tag_t         r_tag [PE_STAGES];
    logic [W-1:0] r_bias_q;
    logic [W-1:0] r_acc;
    logic [W-1:0] r_result;
    logic         r_result_valid;
    logic         r_first_pend;
    logic         w_accept;
    logic         w_start_acc;
    logic [W-1:0] w_acc_sum;
    logic [W-1:0] w_acc_next;

    // A triple transfers in any cycle where in_valid and in_ready are both high;
    // in_valid may rise or fall freely, in_ready depends only on the FSM state.
    assign w_accept         = in_valid & in_ready;
    assign pe_on_3mul_pe_en = w_accept;
    assign pe_data3_o       = data3_i;
    assign pe_ker3_o        = ker3_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start)                w_next = ST_RUN;
            ST_RUN:   if (w_accept && in_last)  w_next = ST_DRAIN;
            ST_DRAIN: if (r_result_valid)       w_next = ST_IDLE;
            default:                            w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (r_state == ST_RUN);
        busy        = (r_state != ST_IDLE);
        w_start_acc = (r_state == ST_IDLE) && start;
        o_dbg_state = r_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bias_q     <= '0;
            r_first_pend <= 1'b0;
        end else if (w_start_acc) begin
            r_bias_q     <= bias_i;
            r_first_pend <= 1'b1;
        end else if (w_accept) begin
            r_first_pend <= 1'b0;
        end
    end

    // Non-accept cycles shift in an empty tag, which masks the stale PE registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < PE_STAGES; k++) r_tag[k] <= '0;
        end else begin
            r_tag[0] <= {w_accept, w_accept & r_first_pend, w_accept & in_last};
            for (int k = 1; k < PE_STAGES; k++) r_tag[k] <= r_tag[k-1];
        end
    end

    assign pe_on_align3 = r_tag[STAGE_ALIGN].v;
    assign pe_on_sum3   = r_tag[STAGE_SUM].v;
    assign pe_on_bias   = r_tag[STAGE_BIAS].v;
    assign pe_bias_o    = (r_tag[STAGE_BIAS].v && r_tag[STAGE_BIAS].first) ? r_bias_q : '0;

    fp_adder2 #(
        .EXPONENT (EXPONENT),
        .MANTISSA (MANTISSA)
    ) u_acc_add (
        .i_a   (r_acc),
        .i_b   (pe_data_i),
        .o_sum (w_acc_sum)
    );

    assign w_acc_next = r_tag[STAGE_RET].first ? pe_data_i : w_acc_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (r_tag[STAGE_RET].v) begin
                r_acc <= w_acc_next;
                if (r_tag[STAGE_RET].last) begin
                    r_result       <= w_acc_next;
                    r_result_valid <= 1'b1;
                end
            end
        end
    end

    assign result_o     = r_result;
    assign result_valid = r_result_valid;

endmodule

// File: tb/tb_fc_pe_seq.sv
// Bench for fc_pe_seq: a behavioural PE answers the strobes, and results are
// compared against an exact fixed-point reference (values are multiples of 1/4).
module tb_fc_pe_seq;
    import fc_pe_seq_pkg::*;

    localparam int W = 32;
    localparam logic [W-1:0] ONE  = 32'h3F80_0000;
    localparam logic [W-1:0] TWO  = 32'h4000_0000;
    localparam logic [W-1:0] HALF = 32'h3F00_0000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   bias_i = '0;
    logic [3*W-1:0] data3_i = '0;
    logic [3*W-1:0] ker3_i = '0;
    logic           in_valid = 1'b0;
    logic           in_last = 1'b0;
    logic           in_ready;
    logic [3*W-1:0] pe_data3_o;
    logic [3*W-1:0] pe_ker3_o;
    logic [W-1:0]   pe_bias_o;
    logic           pe_on_3mul_pe_en;
    logic           pe_on_align3;
    logic           pe_on_sum3;
    logic           pe_on_bias;
    logic [W-1:0]   pe_data_i;
    logic [W-1:0]   result_o;
    logic           result_valid;
    logic           busy;
    logic [1:0]     dbg_state;

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_comb_err = 0;
    int cyc = 0;
    int q_acc[$];
    int q_al[$];
    int q_su[$];
    int q_bi[$];
    int q_rs[$];
    logic [W-1:0] q_bv[$];
    logic [W-1:0] exp_q[$];
    int pm_mul = 0;
    int pm_al = 0;
    int pm_sum = 0;
    int pm_out = 0;

    fc_pe_seq dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .bias_i           (bias_i),
        .data3_i          (data3_i),
        .ker3_i           (ker3_i),
        .in_valid         (in_valid),
        .in_last          (in_last),
        .in_ready         (in_ready),
        .pe_data3_o       (pe_data3_o),
        .pe_ker3_o        (pe_ker3_o),
        .pe_bias_o        (pe_bias_o),
        .pe_on_3mul_pe_en (pe_on_3mul_pe_en),
        .pe_on_align3     (pe_on_align3),
        .pe_on_sum3       (pe_on_sum3),
        .pe_on_bias       (pe_on_bias),
        .pe_data_i        (pe_data_i),
        .result_o         (result_o),
        .result_valid     (result_valid),
        .busy             (busy),
        .o_dbg_state      (dbg_state)
    );

    // ---------------- clock / reset timebase ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1);
    end

    // ---------------- fixed-point <-> fp32 helpers (unit = 1/16) ----------------
    function automatic logic [31:0] enc16(input int v);
        logic [31:0] mag;
        logic [31:0] frac;
        int p;
        if (v == 0) return 32'h0;
        mag = (v < 0) ? 32'(-v) : 32'(v);
        p = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) p = i;
        frac = (mag << (23 - p)) & 32'h007F_FFFF;
        return {v < 0, 8'(p + 123), frac[22:0]};
    endfunction

    function automatic int dec16(input logic [31:0] b);
        int e;
        int r;
        logic [31:0] full;
        e = int'(b[30:23]);
        if (e == 0) return 0;
        full = {8'h00, 1'b1, b[22:0]};
        if (e >= 146) r = int'(full << (e - 146));
        else          r = int'(full >> (146 - e));
        return b[31] ? -r : r;
    endfunction

    function automatic int dot16(input logic [3*W-1:0] d, input logic [3*W-1:0] k);
        int s;
        s = 0;
        for (int i = 0; i < 3; i++) s += dec16(d[i*W +: W]) * dec16(k[i*W +: W]) / 16;
        return s;
    endfunction

    // ---------------- behavioural PE driven by the DUT strobes ----------------
    always @(posedge clk) begin
        if (pe_on_3mul_pe_en) pm_mul <= dot16(pe_data3_o, pe_ker3_o);
        if (pe_on_align3)     pm_al  <= pm_mul;
        if (pe_on_sum3)       pm_sum <= pm_al;
        if (pe_on_bias)       pm_out <= pm_sum + dec16(pe_bias_o);
    end
    assign pe_data_i = enc16(pm_out);

    // ---------------- event log, sampled mid-cycle ----------------
    always @(negedge clk) begin
        if (in_valid && in_ready) q_acc.push_back(cyc);
        if (pe_on_3mul_pe_en !== (in_valid & in_ready)) n_comb_err++;
        if (pe_data3_o !== data3_i || pe_ker3_o !== ker3_i) n_comb_err++;
        if (pe_on_align3) q_al.push_back(cyc);
        if (pe_on_sum3) q_su.push_back(cyc);
        if (pe_on_bias) begin
            q_bi.push_back(cyc);
            q_bv.push_back(pe_bias_o);
        end
        if (result_valid) q_rs.push_back(cyc);
    end

    // ---------------- scoreboard / driver tasks ----------------
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        q_acc.delete(); q_al.delete(); q_su.delete();
        q_bi.delete(); q_bv.delete(); q_rs.delete();
    endtask

    task automatic bubble(input int n);
        repeat (n) tick();
    endtask

    task automatic do_start(input logic [W-1:0] b);
        start = 1'b1;
        bias_i = b;
        tick();
        start = 1'b0;
        bias_i = $urandom;
    endtask

    task automatic send_triple(input logic [3*W-1:0] d, input logic [3*W-1:0] k, input logic last);
        int n;
        n = 0;
        data3_i = d; ker3_i = k; in_last = last; in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_result(input int limit, output logic [W-1:0] res, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        res = 'x;
        while (n < limit && !ok) begin
            if (result_valid === 1'b1) begin
                ok = 1'b1;
                res = result_o;
            end else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic check_pipe(input string tag, input logic [W-1:0] b);
        int bad_t;
        int bad_b;
        int lat;
        bad_t = 0;
        bad_b = 0;
        if (q_al.size() != q_acc.size() || q_su.size() != q_acc.size() || q_bi.size() != q_acc.size())
            bad_t = 1;
        else
            foreach (q_acc[i])
                if (q_al[i] != q_acc[i] + 1 || q_su[i] != q_acc[i] + 2 || q_bi[i] != q_acc[i] + 3) bad_t++;
        foreach (q_bv[i]) if (q_bv[i] !== ((i == 0) ? b : 32'h0)) bad_b++;
        lat = (q_rs.size() > 0 && q_acc.size() > 0) ? q_rs[0] - q_acc[$] : -1;
        check({tag, "_strobe_timing"}, bad_t, 0);
        check({tag, "_bias_inject"}, bad_b, 0);
        check({tag, "_result_pulses"}, q_rs.size(), 1);
        check({tag, "_result_latency"}, lat, 5);
        check({tag, "_comb_paths"}, n_comb_err, 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [W-1:0] res;
        bit ok;
        int nt;
        int kb;
        int model;
        int kd [3];
        int kk [3];
        logic [3*W-1:0] d;
        logic [3*W-1:0] k;
        logic [W-1:0] b;

        rst = 1'b1;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_result_valid", 32'(result_valid), 0);
        check("rst_result_o", result_o, 0);
        check("rst_strobes", {28'h0, pe_on_3mul_pe_en, pe_on_align3, pe_on_sum3, pe_on_bias}, 0);
        check("rst_pe_bias", pe_bias_o, 0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        tick();

        // single triple
        clear_logs();
        do_start(HALF);
        check("t1_ready_after_start", 32'(in_ready), 1);
        check("t1_busy_after_start", 32'(busy), 1);
        check("t1_state_run", 32'(dbg_state), 32'(ST_RUN));
        send_triple({3{ONE}}, {3{TWO}}, 1'b1);
        wait_result(30, res, ok);
        check("t1_found", 32'(ok), 1);
        check("t1_result", res, 32'h40D0_0000);
        check("t1_busy_at_result", 32'(busy), 1);
        tick();
        check("t1_busy_drop", 32'(busy), 0);
        check("t1_rv_one_cycle", 32'(result_valid), 0);
        check("t1_result_held", result_o, 32'h40D0_0000);
        check_pipe("t1", HALF);

        // two back-to-back triples
        clear_logs();
        do_start(HALF);
        send_triple({3{ONE}}, {3{TWO}}, 1'b0);
        send_triple({3{ONE}}, {3{ONE}}, 1'b1);
        wait_result(30, res, ok);
        check("t2_result", res, 32'h4118_0000);
        tick();
        check_pipe("t2", HALF);

        // bubbles between the triples
        clear_logs();
        do_start(HALF);
        send_triple({3{ONE}}, {3{TWO}}, 1'b0);
        bubble(3);
        send_triple({3{ONE}}, {3{ONE}}, 1'b1);
        wait_result(30, res, ok);
        check("t3_result", res, 32'h4118_0000);
        tick();
        check_pipe("t3", HALF);

        // start during RUN is ignored
        clear_logs();
        do_start(HALF);
        send_triple({3{ONE}}, {3{TWO}}, 1'b0);
        start = 1'b1;
        bias_i = 32'h42C8_0000;
        tick();
        start = 1'b0;
        check("t4_ready_kept", 32'(in_ready), 1);
        send_triple({3{ONE}}, {3{ONE}}, 1'b1);
        wait_result(30, res, ok);
        check("t4_result", res, 32'h4118_0000);
        tick();
        check_pipe("t4", HALF);
        tick();
        check("t4_idle_after", 32'(busy), 0);

        // reset two cycles after the first accept
        clear_logs();
        do_start(HALF);
        send_triple({3{ONE}}, {3{TWO}}, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        check("t5_rst_in_ready", 32'(in_ready), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_result_o", result_o, 0);
        check("t5_rst_result_valid", 32'(result_valid), 0);
        check("t5_rst_strobes", {29'h0, pe_on_align3, pe_on_sum3, pe_on_bias}, 0);
        check("t5_rst_pe_bias", pe_bias_o, 0);
        bubble(2);
        rst = 1'b0;
        bubble(8);
        check("t5_no_result", q_rs.size(), 0);
        clear_logs();
        do_start(HALF);
        send_triple({3{ONE}}, {3{TWO}}, 1'b0);
        send_triple({3{ONE}}, {3{ONE}}, 1'b1);
        wait_result(30, res, ok);
        check("t5_fresh_result", res, 32'h4118_0000);
        tick();
        check_pipe("t5_fresh", HALF);

        // random vectors with random bubbles
        for (int v = 0; v < 100; v++) begin
            clear_logs();
            kb = int'($urandom_range(0, 16)) - 8;
            b = enc16(4 * kb);
            model = 4 * kb;
            do_start(b);
            nt = int'($urandom_range(1, 20));
            for (int j = 0; j < nt; j++) begin
                if ($urandom_range(0, 3) == 0) bubble(int'($urandom_range(1, 3)));
                for (int l = 0; l < 3; l++) begin
                    kd[l] = int'($urandom_range(0, 16)) - 8;
                    kk[l] = int'($urandom_range(0, 16)) - 8;
                    d[l*W +: W] = enc16(4 * kd[l]);
                    k[l*W +: W] = enc16(4 * kk[l]);
                    model += kd[l] * kk[l];
                end
                send_triple(d, k, j == nt - 1);
            end
            exp_q.push_back(enc16(model));
            wait_result(40, res, ok);
            check($sformatf("rand%0d_result", v), res, exp_q.pop_front());
            tick();
            check($sformatf("rand%0d_busy_drop", v), 32'(busy), 0);
            check_pipe($sformatf("rand%0d", v), b);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
